// File: rtl/aes_pkg.sv
// Shared definitions for the Rijndael state permutation units: row offset table,
// column-major byte indexing and the legal block-width check.
package aes_pkg;

    // Row offsets indexed by [width select][row]; width select 0/1/2 = Nb 4/6/8.
    localparam int ROW_OFF [3][4] = '{'{0, 1, 2, 3}, '{0, 1, 2, 3}, '{0, 1, 3, 4}};

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    function automatic int row_offset(input int nb, input int r);
        int sel;
        sel = (nb == 8) ? 2 : ((nb == 6) ? 1 : 0);
        return ROW_OFF[sel][r];
    endfunction

    function automatic int state_byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/aes_shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; byte 0 is the MSB byte
// and bytes are laid out column-major.
module aes_shiftrows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic              inv,
    input  logic [32*NB-1:0]  data,
    output logic [32*NB-1:0]  perm
);

    localparam int W = 32 * NB;

    logic [W-1:0] fwd;
    logic [W-1:0] bwd;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF = row_offset(NB, r);
            localparam int DST = state_byte_idx(r, c);
            localparam int SRC_F = state_byte_idx(r, (c + OFF) % NB);
            localparam int SRC_I = state_byte_idx(r, (c - OFF + NB) % NB);
            assign fwd[W-1-8*DST -: 8] = data[W-1-8*SRC_F -: 8];
            assign bwd[W-1-8*DST -: 8] = data[W-1-8*SRC_I -: 8];
        end
    end

    assign perm = inv ? bwd : fwd;

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Pipelined ShiftRows / InvShiftRows with valid/ready handshake, per-transaction
// mode select and a pass-through tag; empty stages fill even while stalled.
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [32*NB-1:0]  in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        occupancy
);

    localparam int W = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_shiftrows_pipe: STAGES must be in 1..4");
    end

    logic [W-1:0]     perm_data;
    logic [W-1:0]     data_p [1:STAGES];
    logic [TAG_W-1:0] tag_p  [1:STAGES];
    logic [STAGES:1]  vld_p;
    logic [STAGES:1]  adv;
    logic [2:0]       occ;
    logic             in_xfer;
    logic             out_xfer;

    aes_shiftrows_perm #(.NB(NB)) u_perm (
        .inv  (in_inv),
        .data (in_data),
        .perm (perm_data)
    );

    // Stage i advances unless it and every stage after it are full while the output stalls.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int i = STAGES; i >= 1; i--) begin
            all_full = all_full & vld_p[i];
            adv[i]   = out_ready | ~all_full;
        end
    end

    assign in_ready  = adv[1];
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = vld_p[STAGES];
    assign out_xfer  = out_valid & out_ready;
    assign out_data  = data_p[STAGES];
    assign out_tag   = tag_p[STAGES];
    assign occupancy = occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            occ   <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                data_p[i] <= '0;
                tag_p[i]  <= '0;
            end
        end else begin
            // stage 1: capture the permuted state on input transfer
            if (adv[1]) begin
                vld_p[1] <= in_valid;
                if (in_valid) begin
                    data_p[1] <= perm_data;
                    tag_p[1]  <= in_tag;
                end
            end
            // stages 2..STAGES: plain shift of valid/data/tag
            for (int i = 2; i <= STAGES; i++) begin
                if (adv[i]) begin
                    vld_p[i] <= vld_p[i-1];
                    if (vld_p[i-1]) begin
                        data_p[i] <= data_p[i-1];
                        tag_p[i]  <= tag_p[i-1];
                    end
                end
            end
            occ <= occ + {2'b00, in_xfer} - {2'b00, out_xfer};
        end
    end

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Randomised and directed bench for aes_shiftrows_pipe at NB = 4, 8 and 6,
// checked against a byte-array reference of ShiftRows / InvShiftRows.
module tb_aes_shiftrows_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: NB=4, STAGES=3
    logic         a_in_valid = 0, a_in_ready, a_in_inv = 0, a_out_valid, a_out_ready = 1;
    logic [127:0] a_in_data = '0, a_out_data;
    logic [3:0]   a_in_tag = '0, a_out_tag;
    logic [2:0]   a_occ;

    // DUT B: NB=8, STAGES=2 and DUT C: NB=6, STAGES=1 share the input side
    logic         bc_in_valid = 0, bc_in_inv = 0;
    logic [255:0] bc_in_data = '0;
    logic [3:0]   bc_in_tag = '0;
    logic         b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [255:0] b_out_data;
    logic [191:0] c_out_data;
    logic [3:0]   b_out_tag, c_out_tag;
    logic [2:0]   b_occ, c_occ;

    aes_shiftrows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
        .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_tag(a_out_tag), .occupancy(a_occ));

    aes_shiftrows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(bc_in_valid), .in_ready(b_in_ready), .in_inv(bc_in_inv),
        .in_data(bc_in_data), .in_tag(bc_in_tag), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_tag(b_out_tag), .occupancy(b_occ));

    aes_shiftrows_pipe #(.NB(6), .STAGES(1), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(bc_in_valid), .in_ready(c_in_ready), .in_inv(bc_in_inv),
        .in_data(bc_in_data[191:0]), .in_tag(bc_in_tag), .out_valid(c_out_valid), .out_ready(1'b1),
        .out_data(c_out_data), .out_tag(c_out_tag), .occupancy(c_occ));

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference: unpack to bytes, rotate each row by its offset, repack.
    function automatic logic [255:0] model(input int nb, input logic inv, input logic [255:0] x);
        logic [7:0]   bi [32];
        logic [7:0]   bo [32];
        logic [255:0] y;
        int           off [4];
        int           w;
        int           src;
        w = 32 * nb;
        y = '0;
        off[0] = 0; off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int k = 0; k < 32; k++) begin
            bi[k] = '0;
            bo[k] = '0;
        end
        for (int k = 0; k < 4 * nb; k++) bi[k] = x[w-1-8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                bo[4*c + r] = bi[4*src + r];
            end
        end
        for (int k = 0; k < 4 * nb; k++) y[w-1-8*k -: 8] = bo[k];
        return y;
    endfunction

    typedef struct {
        logic [255:0] data;
        logic [3:0]   tag;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    item_t qc[$];

    // Record every accepted input with its expected permuted value.
    initial forever begin
        item_t it;
        @(posedge clk);
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
        end else begin
            if (a_in_valid && a_in_ready) begin
                it.data = model(4, a_in_inv, {128'b0, a_in_data});
                it.tag  = a_in_tag;
                qa.push_back(it);
            end
            if (bc_in_valid && b_in_ready) begin
                it.data = model(8, bc_in_inv, bc_in_data);
                it.tag  = bc_in_tag;
                qb.push_back(it);
            end
            if (bc_in_valid && c_in_ready) begin
                it.data = model(6, bc_in_inv, {64'b0, bc_in_data[191:0]});
                it.tag  = bc_in_tag;
                qc.push_back(it);
            end
        end
    end

    // Compare process: runs every cycle on the falling edge.
    logic         a_stall_prev = 0;
    logic [127:0] a_prev_data;
    logic [3:0]   a_prev_tag;

    initial forever begin
        item_t e;
        @(negedge clk);
        if (rst) begin
            a_stall_prev = 0;
        end else begin
            chk("a_occupancy", a_occ, qa.size());
            chk("a_in_ready", a_in_ready, !(qa.size() == 3 && !a_out_ready));
            if (a_stall_prev) begin
                chk("a_stall_valid", a_out_valid, 1);
                chk("a_stall_data", a_out_data, a_prev_data);
                chk("a_stall_tag", a_out_tag, a_prev_tag);
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_spurious_out", a_out_tag, 'hx);
                else begin
                    e = qa.pop_front();
                    chk("a_data", a_out_data, e.data);
                    chk("a_tag", a_out_tag, e.tag);
                end
            end
            a_stall_prev = a_out_valid && !a_out_ready;
            a_prev_data  = a_out_data;
            a_prev_tag   = a_out_tag;

            chk("b_occupancy", b_occ, qb.size());
            if (b_out_valid) begin
                if (qb.size() == 0) chk("b_spurious_out", b_out_tag, 'hx);
                else begin
                    e = qb.pop_front();
                    chk("b_data", b_out_data, e.data);
                    chk("b_tag", b_out_tag, e.tag);
                end
            end
            chk("c_occupancy", c_occ, qc.size());
            if (c_out_valid) begin
                if (qc.size() == 0) chk("c_spurious_out", c_out_tag, 'hx);
                else begin
                    e = qc.pop_front();
                    chk("c_data", c_out_data, e.data);
                    chk("c_tag", c_out_tag, e.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic inv, input logic [127:0] d, input logic [3:0] tag);
        bit done;
        done = 0;
        a_in_valid = 1; a_in_inv = inv; a_in_data = d; a_in_tag = tag;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = a_in_ready;
            tick();
        end
        a_in_valid = 0;
        if (!done) chk("a_send_timeout", 0, 1);
    endtask

    task automatic bc_send(input logic inv, input logic [255:0] d, input logic [3:0] tag);
        bit done;
        done = 0;
        bc_in_valid = 1; bc_in_inv = inv; bc_in_data = d; bc_in_tag = tag;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = b_in_ready && c_in_ready;
            tick();
        end
        bc_in_valid = 0;
        if (!done) chk("bc_send_timeout", 0, 1);
    endtask

    task automatic a_drain();
        a_out_ready = 1;
        for (int n = 0; n < 30 && qa.size() != 0; n++) tick();
        chk("a_drain_empty", qa.size(), 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    initial begin
        logic [255:0] seq8, seq6, res;
        logic [127:0] cur;
        int           n, t;
        bit           acc, saw_full;

        seq8 = '0;
        seq6 = '0;
        for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = 8'(k);
        for (int k = 0; k < 24; k++) seq6[191-8*k -: 8] = 8'(k);

        // Pin the reference model with hand-computed values
        res = model(4, 0, {128'b0, FIPS_IN});
        chk("model_fips_fwd", res, {128'b0, FIPS_OUT});
        res = model(4, 1, {128'b0, FIPS_OUT});
        chk("model_fips_inv", res, {128'b0, FIPS_IN});
        res = model(8, 0, seq8);
        chk("model_nb8_col0", res[255 -: 32], 32'h00050E13);
        res = model(6, 0, seq6);
        chk("model_nb6_col0", res[191 -: 32], 32'h00050A0F);

        // Reset state
        rst = 1;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_occupancy", a_occ, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_tag", a_out_tag, 0);
        chk("rst_in_ready", a_in_ready, 1);
        tick();

        // FIPS-197 forward vector and latency
        a_out_ready = 1;
        a_send(0, FIPS_IN, 4'h1);
        n = 1;
        while (!a_out_valid && n < 10) begin tick(); n++; end
        chk("latency_fwd", n, 3);
        chk("fips_fwd_dut", a_out_data, FIPS_OUT);
        tick();

        // Round trip via inverse
        a_send(1, FIPS_OUT, 4'h2);
        n = 1;
        while (!a_out_valid && n < 10) begin tick(); n++; end
        chk("latency_inv", n, 3);
        chk("fips_inv_dut", a_out_data, FIPS_IN);
        a_drain();

        // Interleaved random forward/inverse, back to back
        for (int i = 0; i < 16; i++) a_send(1'($urandom_range(0, 1)), rnd128(), 4'(i));
        a_drain();

        // Backpressure: tags 0..7 with out_ready pattern 1,0,0
        t = 0; saw_full = 0; cur = rnd128();
        for (int cyc = 0; cyc < 200 && t < 8; cyc++) begin
            a_out_ready = (cyc % 3 == 0);
            a_in_valid = 1; a_in_tag = 4'(t); a_in_data = cur; a_in_inv = 1'(t);
            @(negedge clk);
            if (a_occ == 3 && !a_out_ready) begin
                saw_full = 1;
                chk("bp_full_ready_low", a_in_ready, 0);
            end
            acc = a_in_ready;
            tick();
            if (acc) begin t++; cur = rnd128(); end
        end
        a_in_valid = 0;
        chk("bp_all_sent", t, 8);
        chk("bp_reached_full", saw_full, 1);
        a_drain();

        // Full pipe with simultaneous input and output transfers
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) a_send(0, rnd128(), 4'(8 + i));
        @(negedge clk);
        chk("fill_occupancy", a_occ, 3);
        tick();
        a_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1; a_in_inv = 1'(i); a_in_data = rnd128(); a_in_tag = 4'(i);
            @(negedge clk);
            chk("sim_occupancy", a_occ, 3);
            chk("sim_in_ready", a_in_ready, 1);
            chk("sim_out_valid", a_out_valid, 1);
            tick();
        end
        a_in_valid = 0;
        a_drain();

        // Reset mid-stream with two states in flight
        a_out_ready = 0;
        a_send(0, rnd128(), 4'hA);
        a_send(1, rnd128(), 4'hB);
        @(negedge clk);
        chk("pre_rst_occupancy", a_occ, 2);
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_occupancy", a_occ, 0);
        chk("mid_rst_out_data", a_out_data, 0);
        chk("mid_rst_out_tag", a_out_tag, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);
        tick();
        a_out_ready = 1;
        repeat (6) tick();

        // NB = 8 and NB = 6 directed vectors
        bc_send(0, seq8, 4'h1);
        tick();
        chk("nb8_out_valid", b_out_valid, 1);
        chk("nb8_col0", b_out_data[255 -: 32], 32'h00050E13);
        res = b_out_data;
        bc_send(1, res, 4'h2);
        tick();
        chk("nb8_roundtrip", b_out_data, seq8);
        tick();
        bc_send(0, {64'b0, seq6[191:0]}, 4'h3);
        chk("nb6_out_valid", c_out_valid, 1);
        chk("nb6_col0", c_out_data[191 -: 32], 32'h00050A0F);
        repeat (3) tick();

        // Random mixed-mode stream for NB = 8 / NB = 6
        for (int i = 0; i < 20; i++)
            bc_send(1'($urandom_range(0, 1)), {rnd128(), rnd128()}, 4'(i));
        repeat (5) tick();

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        chk("end_qc_empty", qc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_shiftrows_pipe.md
Name: aes_shiftrows_pipe

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit with a valid/ready handshake.
- Supports block widths Nb = 4, 6 or 8 columns, which is 128/192/256-bit state.
- Forward or inverse mode is selected per transaction.
- Sits between SubBytes and MixColumns in the round datapath. An opaque tag travels with each state so the round controller can track in-flight blocks.

Parameters:
- NB, 4, number of state columns. Legal values: 4, 6, 8; any other value is an elaboration error. State width W = 32*NB.
- STAGES, 1, pipeline register depth. Legal values: 1..4.
- TAG_W, 4, width of the pass-through tag.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input state is valid
- in_ready  output  1  unit accepts input this cycle
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
- in_data  input  W  input state
- in_tag  input  TAG_W  transaction tag
- out_valid  output  1  output state is valid
- out_ready  input  1  downstream accepts the output
- out_data  output  W  permuted state
- out_tag  output  TAG_W  tag of out_data
- occupancy  output  3  number of valid pipeline stages, 0..STAGES

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Byte layout: column-major. Byte k = 4c + r (row r, column c) occupies bits [W-1-8k -: 8], so byte 0 is the MSB byte.
- Row offsets:
  - NB = 4 and NB = 6: row 0..3 offsets are 0, 1, 2, 3.
  - NB = 8: row 0..3 offsets are 0, 1, 3, 4.
- Forward mapping: out(r,c) = in(r, (c + off[r]) mod NB).
- Inverse mapping: out(r,c) = in(r, (c - off[r] + NB) mod NB).
- Datapath: the permutation is combinational on in_data and is captured into stage 1 on acceptance. Stages 2..STAGES are plain data/tag/valid registers. Row 0 is never moved.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Stage i advances when stage i is empty, or when stage i+1 advances (stage STAGES+1 advances when out_ready = 1).
  - in_ready = stage 1 advance condition. in_ready is combinational from out_ready through the chain; there is no combinational path from in_valid to in_ready.
  - Bubbles collapse: empty stages fill even while the output is stalled.
- Latency: exactly STAGES cycles from the input transfer to out_valid when there is no backpressure. Throughput is 1 state per cycle.
- Stall: while out_valid = 1 and out_ready = 0, out_data and out_tag hold stable and out_valid stays high. in_valid may drop after acceptance without affecting anything.
- Mode: each transaction carries its own in_inv. Forward and inverse states may be interleaved back-to-back with no bubble.
- occupancy: counts valid stages. It updates in the same cycle as the valid bits. Input and output transfers in the same cycle leave it unchanged. It never exceeds STAGES.
- Reset, applied in any state including mid-stream:
  - All stage valid bits clear; out_valid = 0.
  - out_data = 0, out_tag = 0, occupancy = 0.
  - in_ready = 1 in the first cycle after reset.
  - In-flight states are discarded; no partial output appears.
- No X propagation: data registers are reset, and data/tag are loaded only on transfer.

Decomposition:
- Shared package aes_pkg holds:
  - constant table of row offsets per NB;
  - function state_byte_idx(r, c) giving the column-major byte index;
  - legal-NB check.
- One natural sub-module: aes_shiftrows_perm (purely combinational, parameters NB and inverse-select input). It generates the byte permutation from the offset table; the top instantiates it once ahead of stage 1.

Test Plan:
- FIPS-197 vector, NB = 4, forward: in_data = d42711ae e0bf98f1 b8b45de5 1e415230, in_inv = 0 -> out_data = d4bf5d30 e0b452ae b84111f1 1e2798e5. out_valid rises exactly STAGES cycles after acceptance.
- Round trip, NB = 4: feed the FIPS-197 output above with in_inv = 1 -> out_data = d42711ae e0bf98f1 b8b45de5 1e415230. Interleave forward and inverse states on consecutive cycles; every output matches its own mode and tag.
- NB = 8 forward: in_data bytes k = 0x00..0x1F -> first output column 00 05 0E 13. Inverse of that result restores 00..1F. NB = 6 uses offsets 0, 1, 2, 3.
- Backpressure, STAGES = 3: stream tags 0..7 with out_ready toggling 1,0,0,1,... -> no tag lost or duplicated, order preserved, out_data stable during stalls. occupancy reaches 3 and in_ready = 0 while full and stalled.
- Full pipe with simultaneous transfers: out_ready = 1 and in_valid = 1 together -> occupancy stays constant and one state enters and one leaves per cycle.
- Reset mid-stream with 2 states in flight: pulse rst for 1 cycle -> next cycle out_valid = 0, occupancy = 0, out_data = 0, in_ready = 1. The discarded tags never appear at the output.
